// File: rtl/adpll_pkg.sv
// Shared ADPLL types and constants: period-meter FSM states, default counter
// width and the saturation-value helper.
package adpll_pkg;

    typedef enum logic [1:0] {
        PM_IDLE    = 2'd0,
        PM_ARM     = 2'd1,
        PM_MEASURE = 2'd2
    } pm_state_t;

    localparam int PM_CNT_W_DEFAULT = 16;

    // All-ones value of a w-bit counter, i.e. the saturation point.
    function automatic logic [63:0] pm_sat_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Conditions an asynchronous input and emits a one-cycle rising-edge pulse.
// PERIOD_METER_SYNC_EN selects a 2-flop synchronizer instead of one sampling flop.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic cond;
    logic cond_dly_q;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sig_i};
        end
    end

    assign cond = sync_q[1];
`else
    logic samp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q <= 1'b0;
        end else begin
            samp_q <= sig_i;
        end
    end

    assign cond = samp_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_dly_q <= 1'b0;
        end else begin
            cond_dly_q <= cond;
        end
    end

    assign rise_o = cond & ~cond_dly_q;

endmodule

// File: rtl/period_meter.sv
// Measures the spacing of rising edges on sig_in in clk cycles and hands each
// result out over valid/ready. Honours PERIOD_METER_SYNC_EN via sync_edge_detect.
module period_meter
    import adpll_pkg::*;
#(
    parameter int CNT_W = PM_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    input  logic             ready,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             overflow,
    output logic             stalled,
    output logic             missed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(pm_sat_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rise;
    pm_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             stalled_q, stalled_d;
    logic             missed_q, missed_d;

    sync_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (sig_in),
        .rise_o (rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        stalled_d = stalled_q;
        missed_d  = missed_q;

        if (!enable) begin
            state_d   = PM_IDLE;
            cnt_d     = '0;
            valid_d   = 1'b0;
            stalled_d = 1'b0;
            missed_d  = 1'b0;
        end else begin
            if (valid_q && ready) begin
                valid_d = 1'b0;
            end
            case (state_q)
                PM_IDLE: begin
                    state_d   = PM_ARM;
                    cnt_d     = '0;
                    valid_d   = 1'b0;
                    stalled_d = 1'b0;
                    missed_d  = 1'b0;
                end
                PM_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = PM_MEASURE;
                    end
                end
                PM_MEASURE: begin
                    if (rise) begin
                        cnt_d     = CNT_ONE;
                        stalled_d = 1'b0;
                        // A pending, unaccepted result wins; the new one is dropped.
                        if (!valid_q || ready) begin
                            period_d = cnt_q;
                            ovf_d    = stalled_q;
                            valid_d  = 1'b1;
                        end else begin
                            missed_d = 1'b1;
                        end
                    end else begin
                        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                        stalled_d = (cnt_d == CNT_MAX);
                    end
                end
                default: begin
                    state_d = PM_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PM_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
            missed_q  <= missed_d;
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign stalled  = stalled_q;
    assign missed   = missed_q;

endmodule
